// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end: PC, single-outstanding request FSM, {pc,inst} queue
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INST_WIDTH   = 32,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                          clk,
    input  logic                          cpu_rst,
    input  logic                          cpu_en,
    input  logic                          redirect_en,
    input  logic [ADDR_WIDTH-1:0]         redirect_addr,
    output logic                          inst_ren,
    output logic [ADDR_WIDTH-1:0]         inst_addr,
    input  logic                          inst_gnt,
    input  logic                          inst_rvalid,
    input  logic [INST_WIDTH-1:0]         inst_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INST_WIDTH-1:0]         out_inst,
    output logic [ADDR_WIDTH-1:0]         out_pc,
    output logic [ADDR_WIDTH-1:0]         fetch_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  req_pc;
    logic [ADDR_WIDTH-1:0]  q_pc   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0]  q_inst [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;

    logic redirect, grant, push, pop;

    assign redirect = redirect_en & cpu_en;
    assign grant    = inst_ren & inst_gnt;
    // A response landing in the redirect cycle belongs to the old path and is never queued.
    assign push     = (state == S_WAIT) & inst_rvalid & ~redirect;
    assign pop      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (grant) begin
                    state_nxt = redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_rvalid) begin
                    state_nxt = S_REQ;
                end else if (redirect) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (inst_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Requests only issue when a queue slot is free for the word they will return.
    always_comb begin
        inst_ren  = (state == S_REQ) & cpu_en & ~cpu_rst & (count < DEPTH_C);
        inst_addr = fetch_pc;
        out_valid = (count != '0) & cpu_en & ~cpu_rst;
    end

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            fetch_pc <= RESET_VECTOR;
            req_pc   <= RESET_VECTOR;
        end else begin
            if (grant) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_addr & ~ADDR_WIDTH'(3);
            end else if (grant) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_rst || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]   <= req_pc;
                q_inst[wr_ptr] <= inst_data;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign out_inst   = q_inst[rd_ptr];
    assign out_pc     = q_pc[rd_ptr];
    assign fifo_count = count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int D  = 4;

    logic          clk;
    logic          cpu_rst;
    logic          cpu_en;
    logic          redirect_en;
    logic [AW-1:0] redirect_addr;
    logic          inst_ren;
    logic [AW-1:0] inst_addr;
    logic          inst_gnt;
    logic          inst_rvalid;
    logic [IW-1:0] inst_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] fetch_pc;
    logic [$clog2(D):0] fifo_count;

    inst_fetch_unit #(
        .ADDR_WIDTH   (AW),
        .INST_WIDTH   (IW),
        .FIFO_DEPTH   (D),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk           (clk),
        .cpu_rst       (cpu_rst),
        .cpu_en        (cpu_en),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .inst_ren      (inst_ren),
        .inst_addr     (inst_addr),
        .inst_gnt      (inst_gnt),
        .inst_rvalid   (inst_rvalid),
        .inst_data     (inst_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .fetch_pc      (fetch_pc),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_drop;

    int          mem_cnt;
    logic [31:0] mem_data;

    int          p_gnt, p_ready, p_en, p_redir, lat_min, lat_max;
    bit          force_redir;
    logic [31:0] force_addr;

    int n_cmp;
    int n_err;
    int n_pop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus and memory responder: drive just after each rising edge.
    initial begin
        inst_gnt = 0; out_ready = 0; cpu_en = 0; redirect_en = 0;
        redirect_addr = 0; inst_rvalid = 0; inst_data = 0;
        forever begin
            @(posedge clk);
            #1;
            inst_gnt  = ($urandom_range(99) < p_gnt);
            out_ready = ($urandom_range(99) < p_ready);
            cpu_en    = ($urandom_range(99) < p_en);
            if (force_redir) begin
                redirect_en   = 1'b1;
                redirect_addr = force_addr;
                cpu_en        = 1'b1;
                force_redir   = 1'b0;
            end else begin
                redirect_en   = ($urandom_range(99) < p_redir);
                redirect_addr = $urandom;
            end
            inst_rvalid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    inst_rvalid = 1'b1;
                    inst_data   = mem_data;
                end
            end
        end
    end

    // Reference model: checks control outputs, then applies this cycle's events.
    initial begin
        bit exp_ren, redir, grant;
        forever begin
            @(negedge clk);
            if (cpu_rst) begin
                chk("ren_in_reset", {31'b0, inst_ren}, 32'd0);
                chk("valid_in_reset", {31'b0, out_valid}, 32'd0);
                #2;
                exp_q.delete();
                m_pc = 32'h0; m_out = 0; m_drop = 0; mem_cnt = 0;
            end else begin
                exp_ren = cpu_en && !m_out && (exp_q.size() < D);
                chk("inst_ren", {31'b0, inst_ren}, {31'b0, exp_ren});
                chk("fetch_pc", fetch_pc, m_pc);
                chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
                chk("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() > 0) && cpu_en});
                if (inst_ren) chk("inst_addr", inst_addr, m_pc);
                #2;
                redir = redirect_en && cpu_en;
                grant = exp_ren && inst_gnt;
                if (inst_rvalid && m_out) begin
                    if (!m_drop && !redir) exp_q.push_back({m_req_pc, inst_data});
                    m_out = 0; m_drop = 0;
                end
                if (grant) begin
                    m_out = 1; m_drop = 0;
                    m_req_pc = m_pc;
                    m_pc = m_pc + 32'd4;
                    mem_cnt  = $urandom_range(lat_max, lat_min);
                    mem_data = $urandom;
                end
                if (redir) begin
                    exp_q.delete();
                    if (m_out) m_drop = 1;
                    m_pc = redirect_addr & ~32'h3;
                end
            end
        end
    end

    // Monitor: every consumed head must match the scoreboard front.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!cpu_rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL pop_empty: got pc %h inst %h expected no entry", out_pc, out_inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", out_inst, e.inst);
                    n_pop++;
                end
            end
        end
    end

    task automatic set_knobs(input int g, input int r, input int en, input int rd, input int lmin, input int lmax);
        p_gnt = g; p_ready = r; p_en = en; p_redir = rd; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        @(posedge clk);
        force_addr  = a;
        force_redir = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_pop = 0;
        force_redir = 0; force_addr = 0;
        set_knobs(0, 0, 0, 0, 1, 1);
        cpu_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 cpu_rst = 1'b0;
        @(negedge clk);
        chk("reset_fetch_pc", fetch_pc, 32'h0);
        chk("reset_count", 32'(fifo_count), 32'd0);

        // Streaming with 1-cycle memory and free-running decode.
        set_knobs(100, 100, 100, 0, 1, 1);
        repeat (40) @(posedge clk);

        // Decode stalled: queue fills and requests stop.
        set_knobs(100, 0, 100, 0, 1, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("full_count", 32'(fifo_count), D);
        chk("full_ren", {31'b0, inst_ren}, 32'd0);
        set_knobs(100, 100, 100, 0, 1, 1);
        repeat (20) @(posedge clk);

        // Redirect with a slow memory so the stale word is dropped.
        set_knobs(100, 100, 100, 0, 3, 3);
        repeat (5) @(posedge clk);
        redirect_to(32'h103);
        repeat (30) @(posedge clk);

        // PC wrap at the top of the address space.
        set_knobs(100, 100, 100, 0, 1, 1);
        redirect_to(32'hFFFF_FFFE);
        repeat (30) @(posedge clk);

        // Randomized traffic with varied knobs.
        for (int k = 0; k < 6; k++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 10), $urandom_range(100, 50),
                      $urandom_range(15, 0), 1, $urandom_range(5, 1));
            repeat (700) @(posedge clk);
        end

        // Reset while a request is outstanding.
        set_knobs(100, 100, 100, 0, 8, 8);
        for (int i = 0; i < 50 && !m_out; i++) @(posedge clk);
        chk("outstanding_before_reset", {31'b0, m_out}, 32'd1);
        repeat (2) @(posedge clk);
        #1 cpu_rst = 1'b1;
        @(posedge clk);
        #1 cpu_rst = 1'b0;
        @(negedge clk);
        chk("midwait_reset_pc", fetch_pc, 32'h0);
        chk("midwait_reset_count", 32'(fifo_count), 32'd0);
        set_knobs(100, 100, 100, 0, 1, 2);
        repeat (40) @(posedge clk);

        chk("enough_pops", {31'b0, n_pop > 200}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
